// File: rtl/control_unit_if.sv
// Bus between the control unit and the rest of the 8-bit CPU datapath.
// Carries the opcode nibble and flags in, and the control word and T-state out.
interface control_unit_if;
    logic [3:0]  i_opcode;
    logic        i_flag_c;
    logic        i_flag_z;
    logic [15:0] o_ctrl;
    logic [2:0]  o_step;
    logic        o_halted;

    // Datapath/testbench side: drives opcode and flags, observes control word.
    modport master (
        output i_opcode,
        output i_flag_c,
        output i_flag_z,
        input  o_ctrl,
        input  o_step,
        input  o_halted
    );

    // Sequencer side: consumes opcode and flags, produces control word.
    modport slave (
        input  i_opcode,
        input  i_flag_c,
        input  i_flag_z,
        output o_ctrl,
        output o_step,
        output o_halted
    );
endinterface

// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit bus CPU.
// A 3-bit T-state counter walks fetch (T0, T1) and up to three execute
// steps (T2..T4). The control word is decoded combinationally from the
// step, the opcode nibble and the carry/zero flags. An empty execute word
// ends the instruction early, and a word carrying HLT freezes the counter
// until reset.
module control_unit (
    input  logic          i_clk,
    input  logic          i_rst,
    control_unit_if.slave bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    // Control word bit positions.
    localparam int HLT_BIT = 15;

    // Fetch words.
    localparam logic [15:0] W_NONE   = 16'h0000;
    localparam logic [15:0] W_FETCH0 = 16'h4004;  // CO|MI
    localparam logic [15:0] W_FETCH1 = 16'h1408;  // RO|II|CE

    // Execute words.
    localparam logic [15:0] W_IO_MI  = 16'h4800;  // IO|MI
    localparam logic [15:0] W_RO_AI  = 16'h1200;  // RO|AI
    localparam logic [15:0] W_RO_BI  = 16'h1020;  // RO|BI
    localparam logic [15:0] W_ADD    = 16'h0281;  // EO|AI|FI
    localparam logic [15:0] W_SUB    = 16'h02C1;  // EO|AI|SU|FI
    localparam logic [15:0] W_AO_RI  = 16'h2100;  // AO|RI
    localparam logic [15:0] W_IO_AI  = 16'h0A00;  // IO|AI
    localparam logic [15:0] W_JUMP   = 16'h0802;  // IO|J
    localparam logic [15:0] W_OUT    = 16'h0110;  // AO|OI
    localparam logic [15:0] W_HALT   = 16'h8000;  // HLT

    // Opcode map.
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_e       step_r;
    step_e       step_next_s;
    logic [15:0] word_s;

    // Microcode ROM: control word for the current step, opcode and flags.
    always_comb begin
        word_s = W_NONE;
        case (step_r)
            T0: word_s = W_FETCH0;
            T1: word_s = W_FETCH1;
            T2: begin
                case (bus.i_opcode)
                    OP_LDA:  word_s = W_IO_MI;
                    OP_ADD:  word_s = W_IO_MI;
                    OP_SUB:  word_s = W_IO_MI;
                    OP_STA:  word_s = W_IO_MI;
                    OP_LDI:  word_s = W_IO_AI;
                    OP_JMP:  word_s = W_JUMP;
                    OP_JC:   word_s = bus.i_flag_c ? W_JUMP : W_NONE;
                    OP_JZ:   word_s = bus.i_flag_z ? W_JUMP : W_NONE;
                    OP_OUT:  word_s = W_OUT;
                    OP_HLT:  word_s = W_HALT;
                    default: word_s = W_NONE;
                endcase
            end
            T3: begin
                case (bus.i_opcode)
                    OP_LDA:  word_s = W_RO_AI;
                    OP_ADD:  word_s = W_RO_BI;
                    OP_SUB:  word_s = W_RO_BI;
                    OP_STA:  word_s = W_AO_RI;
                    default: word_s = W_NONE;
                endcase
            end
            T4: begin
                case (bus.i_opcode)
                    OP_ADD:  word_s = W_ADD;
                    OP_SUB:  word_s = W_SUB;
                    default: word_s = W_NONE;
                endcase
            end
            default: word_s = W_NONE;
        endcase
    end

    // Next-step logic: fetch always advances; execute ends on an empty
    // word, holds on HLT, and otherwise advances (T4 wraps to T0).
    always_comb begin
        step_next_s = T0;
        case (step_r)
            T0: step_next_s = T1;
            T1: step_next_s = T2;
            T2: begin
                if (word_s == W_NONE) begin
                    step_next_s = T0;
                end else if (word_s[HLT_BIT]) begin
                    step_next_s = T2;
                end else begin
                    step_next_s = T3;
                end
            end
            T3: begin
                if (word_s == W_NONE) begin
                    step_next_s = T0;
                end else begin
                    step_next_s = T4;
                end
            end
            T4: step_next_s = T0;
            default: step_next_s = T0;
        endcase
    end

    // T-state register; reset clears it without waiting for a clock edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            step_r <= T0;
        end else begin
            step_r <= step_next_s;
        end
    end

    // The control word is forced empty for as long as reset is held.
    assign bus.o_ctrl   = i_rst ? W_NONE : word_s;
    assign bus.o_step   = step_r;
    assign bus.o_halted = bus.o_ctrl[HLT_BIT];

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. The driver issues whole instructions,
// pushing the expected (step, control word) sequence computed from the
// instruction table; a negedge monitor pops and compares every cycle the
// sequencer is out of reset.
module tb_control_unit;

    typedef struct packed {
        logic [2:0]  step;
        logic [15:0] ctrl;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    control_unit_if bus_if ();

    control_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execute-step word of an instruction, straight from the opcode table.
    function automatic logic [15:0] exec_word(input int op, input int t,
                                              input bit fc, input bit fz);
        logic [15:0] w;
        w = 16'h0000;
        if (t == 2) begin
            case (op)
                1, 2, 3, 4: w = 16'h4800;
                5:          w = 16'h0A00;
                6:          w = 16'h0802;
                7:          w = fc ? 16'h0802 : 16'h0000;
                8:          w = fz ? 16'h0802 : 16'h0000;
                14:         w = 16'h0110;
                15:         w = 16'h8000;
                default:    w = 16'h0000;
            endcase
        end else if (t == 3) begin
            case (op)
                1:       w = 16'h1200;
                2, 3:    w = 16'h1020;
                4:       w = 16'h2100;
                default: w = 16'h0000;
            endcase
        end else begin
            case (op)
                2:       w = 16'h0281;
                3:       w = 16'h02C1;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    // Pushes the expected cycles of one non-halting instruction and
    // returns how many cycles it lasts.
    function automatic int push_instr(input int op, input bit fc, input bit fz);
        logic [15:0] words[5];
        int used;
        int cycles;
        exp_t e;
        words[0] = 16'h4004;
        words[1] = 16'h1408;
        used = 2;
        for (int t = 2; t <= 4; t++) begin
            words[t] = exec_word(op, t, fc, fz);
            if (words[t] != 16'h0000 && used == t) used = t + 1;
        end
        cycles = (used == 5) ? 5 : used + 1;
        for (int s = 0; s < cycles; s++) begin
            e.step = 3'(s);
            e.ctrl = words[s];
            exp_q.push_back(e);
        end
        return cycles;
    endfunction

    // Monitor: compares every out-of-reset cycle against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cycle got step=%0d ctrl=%h exp=none",
                         bus_if.o_step, bus_if.o_ctrl);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.o_step !== e.step || bus_if.o_ctrl !== e.ctrl ||
                    bus_if.o_halted !== e.ctrl[15]) begin
                    errors++;
                    $display("FAIL seq got step=%0d ctrl=%h halted=%b exp step=%0d ctrl=%h halted=%b",
                             bus_if.o_step, bus_if.o_ctrl, bus_if.o_halted,
                             e.step, e.ctrl, e.ctrl[15]);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus_if.o_ctrl !== 16'h0000 || bus_if.o_step !== 3'd0 ||
            bus_if.o_halted !== 1'b0) begin
            errors++;
            $display("FAIL %s got ctrl=%h step=%0d halted=%b exp ctrl=0000 step=0 halted=0",
                     name, bus_if.o_ctrl, bus_if.o_step, bus_if.o_halted);
        end
    endtask

    // Holds reset for a few cycles with random opcodes, then releases
    // mid-cycle so the next cycle is T0.
    task automatic reset_phase();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.i_opcode = 4'($urandom_range(0, 15));
            bus_if.i_flag_c = 1'($urandom);
            bus_if.i_flag_z = 1'($urandom);
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Runs one instruction from its T0 cycle to the next T0. Flags are
    // toggled inside T2 so the decode must follow them combinationally.
    task automatic run_instr(input int op, input bit fc, input bit fz);
        int cycles;
        cycles = push_instr(op, fc, fz);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_if.i_opcode = 4'(op);
        bus_if.i_flag_c = ~fc;
        bus_if.i_flag_z = ~fz;
        #2;
        bus_if.i_flag_c = fc;
        bus_if.i_flag_z = fz;
        for (int i = 0; i < cycles - 2; i++) begin
            @(posedge clk);
            #1;
            bus_if.i_flag_c = 1'($urandom);
            bus_if.i_flag_z = 1'($urandom);
        end
    endtask

    // Runs an instruction but asserts reset asynchronously after 'hold'
    // execute cycles, checking the outputs clear without a clock edge.
    task automatic run_then_reset(input int op, input int hold, input string name);
        exp_t e;
        logic [15:0] words[5];
        words[0] = 16'h4004;
        words[1] = 16'h1408;
        for (int t = 2; t <= 4; t++) words[t] = exec_word(op, t, 1'b0, 1'b0);
        for (int s = 0; s < 2 + hold; s++) begin
            e.step = (s > 2) ? 3'd2 : 3'(s);
            e.ctrl = (s > 2 && op == 15) ? words[2] : words[(s > 4) ? 4 : s];
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(posedge clk);
        #1 bus_if.i_opcode = 4'(op);
        repeat (hold) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs(name);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.i_opcode = 4'h0;
        bus_if.i_flag_c = 1'b0;
        bus_if.i_flag_z = 1'b0;

        reset_phase();

        // Directed: LDA, SUB, ADD, conditional jumps both ways, undefined.
        run_instr(1, 1'b0, 1'b0);
        run_instr(3, 1'b0, 1'b0);
        run_instr(2, 1'b1, 1'b1);
        run_instr(7, 1'b1, 1'b0);
        run_instr(7, 1'b0, 1'b1);
        run_instr(8, 1'b0, 1'b1);
        run_instr(8, 1'b1, 1'b0);
        run_instr(11, 1'b0, 1'b0);
        run_instr(0, 1'b1, 1'b1);

        // Randomized instruction stream (no HLT).
        for (int i = 0; i < 60; i++) begin
            run_instr($urandom_range(0, 14), 1'($urandom), 1'($urandom));
        end

        // HLT holds at T2 for 22 cycles, then asynchronous reset.
        run_then_reset(15, 22, "hlt_async_reset");
        reset_phase();

        // Reset in the middle of ADD's T3.
        run_instr(4, 1'b0, 1'b0);
        run_then_reset(2, 1, "add_t3_async_reset");
        reset_phase();

        for (int i = 0; i < 10; i++) begin
            run_instr($urandom_range(0, 14), 1'($urandom), 1'($urandom));
        end

        rst = 1'b1;
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        check_reset_outputs("final_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded sequencer for the 8-bit bus CPU. It holds the T-state counter, decodes the opcode nibble of the instruction register together with the carry/zero flags, and drives the 16-bit control word. That word supplies the load and output-enable strobes of every `register` instance (A, B, IR, MAR, OUT), RAM, ALU, flags and program counter. It sits directly upstream of the register file and consumes the IR upper nibble those registers produce.

## Interface
Parameters: none. Opcode map and microcode are fixed.

Ports:
- `i_clk` in 1: system clock; all state changes on the rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_opcode` in 4: IR bits [7:4].
- `i_flag_c` in 1: registered carry flag.
- `i_flag_z` in 1: registered zero flag.
- `o_ctrl` out 16: control word. Bits: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
- `o_step` out 3: current T-state, 0..4.
- `o_halted` out 1: equals `o_ctrl[15]`.

## Operation
- Step counter: 3-bit register. Reset value 0. Advances 0→1→2→3→4→0.
- `o_ctrl` is a combinational decode of (`o_step`, `i_opcode`, flags). While `i_rst` is high, `o_ctrl` is forced to 0x0000.
- Fetch, independent of opcode:
  - T0 = CO|MI (0x4004).
  - T1 = RO|II|CE (0x1408).
- Execute words for T2 / T3 / T4 (`-` means empty, 0x0000):
  - NOP 0x0: - / - / -
  - LDA 0x1: IO|MI 0x4800 / RO|AI 0x1200 / -
  - ADD 0x2: 0x4800 / RO|BI 0x1020 / EO|AI|FI 0x0281
  - SUB 0x3: 0x4800 / 0x1020 / EO|AI|SU|FI 0x02C1
  - STA 0x4: 0x4800 / AO|RI 0x2100 / -
  - LDI 0x5: IO|AI 0x0A00 / - / -
  - JMP 0x6: IO|J 0x0802 / - / -
  - JC 0x7: 0x0802 if `i_flag_c`, else - / - / -
  - JZ 0x8: 0x0802 if `i_flag_z`, else - / - / -
  - OUT 0xE: AO|OI 0x0110 / - / -
  - HLT 0xF: HLT 0x8000 / - / -
  - 0x9–0xD: undefined; behave as NOP.
- Early end: in T2–T4, an empty control word means the next state is T0 instead of step+1. An instruction therefore occupies exactly its used steps plus one empty step, except a full 5-step instruction, which wraps directly from T4 to T0.
  - NOP takes 3 cycles (T0, T1, empty T2).
  - LDA takes 5 cycles (T0–T3, empty T4).
- Halt: when the decoded word contains HLT, the counter holds. `o_step` stays 2 and `o_ctrl` stays 0x8000 until `i_rst`. There is no other exit.
- Flags are sampled combinationally during T2 only. A flag change during T2 changes `o_ctrl` in the same cycle.

## Timing
- Strobes are valid for the whole cycle of their T-state. Consumers act on the rising edge that ends that state.
- The IR loads on the T1→T2 edge, so T2 decodes the new opcode with zero-cycle decode latency.
- Reset assertion clears the step counter immediately (asynchronous) and forces `o_ctrl` to 0, including mid-instruction (e.g. T3 of ADD).
- First cycle after reset deassertion: `o_step`=0, `o_ctrl`=0x4004.
- `i_opcode` may change only at the T1→T2 edge. Outside T2–T4, `o_ctrl` ignores `i_opcode`.
- The counter never reaches 5–7. Unreachable codes must decode to an empty word and next-state 0.

## Test plan
- Reset: hold `i_rst`=1 with any opcode → `o_ctrl`=0x0000, `o_step`=0, `o_halted`=0. On release, first cycle shows 0x4004, then 0x1408.
- LDA: `i_opcode`=0x1 from T2 → step/ctrl sequence 0:0x4004, 1:0x1408, 2:0x4800, 3:0x1200, 4:0x0000, then 0:0x4004.
- SUB: `i_opcode`=0x3 → T2 0x4800, T3 0x1020, T4 0x02C1, then T0 with no empty step. Repeat with ADD and check T4 = 0x0281.
- Conditional jumps:
  - JC with `i_flag_c`=1 → T2 0x0802, T3 0x0000, T0.
  - JC with `i_flag_c`=0 → T2 0x0000, then T0.
  - Same pair for JZ using `i_flag_z`.
- HLT: `i_opcode`=0xF → `o_step` stays 2 and `o_ctrl` 0x8000 for 20+ cycles. Asserting `i_rst` asynchronously (off the clock edge) → `o_ctrl`=0 immediately. After release → 0x4004.
- Undefined opcode and mid-instruction reset:
  - `i_opcode`=0xB → T2 0x0000, then T0.
  - Asserting `i_rst` during T3 of ADD → step returns to 0 without waiting for a clock edge.
